// File: rtl/div_serial_check.sv
// Serial MSB-first divisibility checker: result WIDTH+1 cycles after start accept, ready low while shifting.
// Optional remainder output is enabled by defining DIVSER_REM_OUT_EN.
module div_serial_check #(
   parameter int WIDTH = 8,
   parameter int DIV   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             done,
   output logic             divisible
`ifdef DIVSER_REM_OUT_EN
   ,
   output logic [$clog2(DIV)-1:0] remainder
`endif
);

   localparam int RW = $clog2(DIV);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [RW:0] DIV_W = DIV[RW:0];

   generate
      if (DIV < 2 || DIV > 255 || WIDTH < 1 || WIDTH > 32) begin : g_bad_param
         $error("div_serial_check: illegal WIDTH or DIV parameter");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [RW-1:0]    r_rem;
   logic [CW-1:0]    r_cnt;
   logic             r_divisible;
   logic             w_accept;
   logic             w_last;
   logic [RW:0]      w_t;
   logic [RW-1:0]    w_r_next;

   assign w_accept = start && (r_state != S_SHIFT);
   assign w_last   = (r_cnt == LAST);

   // r < DIV always holds, so 2r+b < 2*DIV and one subtraction reduces it
   assign w_t      = {r_rem, r_shift[WIDTH-1]};
   assign w_r_next = (w_t >= DIV_W) ? RW'(w_t - DIV_W) : w_t[RW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      ready  = 1'b1;
      done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_SHIFT;
         end
         S_SHIFT: begin
            ready = 1'b0;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = start ? S_SHIFT : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift     <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_divisible <= 1'b0;
`ifdef DIVSER_REM_OUT_EN
         remainder   <= '0;
`endif
      end else if (w_accept) begin
         r_shift <= data_in;
         r_rem   <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
         r_shift <= r_shift << 1;
         r_rem   <= w_r_next;
         r_cnt   <= r_cnt + 1'b1;
         // results only move on the edge that enters DONE
         if (w_last) begin
            r_divisible <= (w_r_next == '0);
`ifdef DIVSER_REM_OUT_EN
            remainder   <= w_r_next;
`endif
         end
      end
   end

   assign divisible = r_divisible;

endmodule
